// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operating modes and their encodings.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD_ENC = 2'b00;
    localparam logic [1:0] MODE_SHR_ENC  = 2'b01;
    localparam logic [1:0] MODE_SHL_ENC  = 2'b10;
    localparam logic [1:0] MODE_LOAD_ENC = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD = MODE_HOLD_ENC,
        MODE_SHR  = MODE_SHR_ENC,
        MODE_SHL  = MODE_SHL_ENC,
        MODE_LOAD = MODE_LOAD_ENC
    } mode_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
//   en, mode, sir, sil, d : control and data into the register (driven by master)
//   q, sor, sol           : register contents and its two end bits (driven by slave)
//   count, word_valid     : serial bit count and completed-word pulse (driven by slave)
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    import shift_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);

    logic             en;
    mode_t            mode;
    logic             sir;
    logic             sil;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sor;
    logic             sol;
    logic [CW-1:0]    count;
    logic             word_valid;

    modport master (
        output en, mode, sir, sil, d,
        input  q, sor, sol, count, word_valid
    );

    modport slave (
        input  en, mode, sir, sil, d,
        output q, sor, sol, count, word_valid
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD bit counter with registered wrap pulse.
//   clk, rst : clock, async active-high reset
//   clr      : force count to 0 (highest priority)
//   set1     : restart count at 1 (first bit of a new word)
//   inc      : advance count; wraps MOD-1 -> 0 and pulses wrap
//   cnt      : current count, 0..MOD-1
//   wrap     : one-cycle pulse on the edge the count wraps
module mod_counter #(
    parameter  int unsigned MOD = 8,
    localparam int unsigned CW  = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          set1,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    // Count register; wrap is only ever high for the cycle after the terminal increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (set1) begin
                cnt <= CW'(1);
            end else if (inc) begin
                if (cnt == CW'(MOD - 1)) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a bit counter flagging each completed WIDTH-bit serial word.
//   clk, rst : clock, async active-high reset
//   bus      : univ_shift_reg_if slave (en/mode/sir/sil/d in; q/sor/sol/count/word_valid out)
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    univ_shift_reg_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             last_shl_r;
    logic             last_shl_nxt;
    logic             act;
    logic             dir_shl;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_set1;
    logic [CW-1:0]    cnt;
    logic             wrap;

    // Next data/direction and counter commands.
    always_comb begin
        q_nxt        = q_r;
        last_shl_nxt = last_shl_r;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_set1     = 1'b0;
        act          = bus.en && (bus.mode != MODE_HOLD);
        dir_shl      = (bus.mode == MODE_SHL);

        if (act) begin
            case (bus.mode)
                MODE_SHR:  q_nxt = {bus.sir, q_r[WIDTH-1:1]};
                MODE_SHL:  q_nxt = {q_r[WIDTH-2:0], bus.sil};
                MODE_LOAD: q_nxt = bus.d;
                default:   q_nxt = q_r;
            endcase

            if (bus.mode == MODE_LOAD) begin
                cnt_clr = 1'b1;
            end else begin
                // A direction change discards the partial word; this shift is its first bit.
                last_shl_nxt = dir_shl;
                if (dir_shl != last_shl_r) begin
                    cnt_set1 = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    // Data register and last shift direction (reset direction is right).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r        <= '0;
            last_shl_r <= 1'b0;
        end else begin
            q_r        <= q_nxt;
            last_shl_r <= last_shl_nxt;
        end
    end

    mod_counter #(
        .MOD (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .set1 (cnt_set1),
        .cnt  (cnt),
        .wrap (wrap)
    );

    assign bus.q          = q_r;
    assign bus.sor        = q_r[0];
    assign bus.sol        = q_r[WIDTH-1];
    assign bus.count      = cnt;
    assign bus.word_valid = wrap;

endmodule
